// File: rtl/aes128_key_expand_pkg.sv
// Shared AES-128 constants, types and small word helpers.
package aes128_key_expand_pkg;

    localparam int unsigned AES128_NR = 10;
    localparam int unsigned NUM_KEYS  = AES128_NR + 1;
    localparam int unsigned IDX_W     = 4;
    localparam int unsigned WORD_W    = 32;
    localparam int unsigned BLOCK_W   = 128;

    localparam logic [7:0] RCON_INIT  = 8'h01;
    localparam logic [7:0] XTIME_POLY = 8'h1B;

    typedef logic [WORD_W-1:0]  aes_word_t;
    typedef logic [BLOCK_W-1:0] aes_block_t;

    // Cyclic left rotation of a word by one byte.
    function automatic aes_word_t rot_word(input aes_word_t w);
        return {w[23:0], w[31:24]};
    endfunction

    // Multiply by x in GF(2^8).
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? XTIME_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/aes_rk_store.sv
// Round-key store: 11 x 128-bit entries, one write port, one combinational read port.
// Per-entry valid bits make unwritten entries read as zero.
module aes_rk_store
    import aes128_key_expand_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clr_i,
    input  logic               we_i,
    input  logic [IDX_W-1:0]   widx_i,
    input  logic [BLOCK_W-1:0] wdata_i,
    input  logic [IDX_W-1:0]   ridx_i,
    output logic [BLOCK_W-1:0] rdata_o
);

    aes_block_t          mem_q [NUM_KEYS];
    logic [NUM_KEYS-1:0] vld_q;
    logic [NUM_KEYS-1:0] vld_d;
    logic                w_in_range;
    logic                r_in_range;

    assign w_in_range = (widx_i < IDX_W'(NUM_KEYS));
    assign r_in_range = (ridx_i < IDX_W'(NUM_KEYS));

    // Valid bits: a new expansion invalidates all entries except the one being written.
    always_comb begin
        vld_d = clr_i ? '0 : vld_q;
        if (we_i && w_in_range) begin
            vld_d[widx_i] = 1'b1;
        end
    end

    // Valid register.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    // Key storage, contents do not need reset.
    always_ff @(posedge clk) begin
        if (we_i && w_in_range) begin
            mem_q[widx_i] <= wdata_i;
        end
    end

    // Combinational read, zero for out-of-range or not-yet-written entries.
    always_comb begin
        rdata_o = '0;
        if (r_in_range && vld_q[ridx_i]) begin
            rdata_o = mem_q[ridx_i];
        end
    end

endmodule

// File: rtl/aes128_key_expand.sv
// Sequential AES-128 key schedule: one round key per clock, streamed and stored.
module aes128_key_expand
    import aes128_key_expand_pkg::*;
#(
    parameter int unsigned NR = AES128_NR,
    parameter int unsigned KW = BLOCK_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [KW-1:0] key_in,
    output logic [31:0]   sw_x,
    input  logic [31:0]   sw_y,
    output logic          busy,
    output logic          rk_valid,
    output logic [3:0]    rk_idx,
    output logic [KW-1:0] rk_out,
    output logic          done,
    output logic          keys_ready,
    input  logic [3:0]    rd_idx,
    output logic [KW-1:0] rd_key
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_GEN  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] round_q, round_d;
    logic [7:0]       rcon_q, rcon_d;
    aes_block_t       key_q, key_d;
    logic             busy_q, busy_d;
    logic             rk_valid_q, rk_valid_d;
    logic [IDX_W-1:0] rk_idx_q, rk_idx_d;
    aes_block_t       rk_out_q, rk_out_d;
    logic             done_q, done_d;
    logic             keys_ready_q, keys_ready_d;

    logic             st_clr, st_we;
    logic [IDX_W-1:0] st_widx;
    aes_block_t       st_wdata;

    aes_word_t        t_w, n0, n1, n2, n3;
    aes_block_t       next_key;

    // Round function on the current key; SubWord comes back through sw_y.
    assign sw_x     = rot_word(key_q[31:0]);
    assign t_w      = sw_y ^ {rcon_q, 24'h0};
    assign n0       = key_q[127:96] ^ t_w;
    assign n1       = n0 ^ key_q[95:64];
    assign n2       = n1 ^ key_q[63:32];
    assign n3       = n2 ^ key_q[31:0];
    assign next_key = {n0, n1, n2, n3};

    // Next-state and output logic.
    always_comb begin
        state_d      = state_q;
        round_d      = round_q;
        rcon_d       = rcon_q;
        key_d        = key_q;
        busy_d       = busy_q;
        rk_valid_d   = 1'b0;
        rk_idx_d     = rk_idx_q;
        rk_out_d     = rk_out_q;
        done_d       = 1'b0;
        keys_ready_d = keys_ready_q;
        st_clr       = 1'b0;
        st_we        = 1'b0;
        st_widx      = '0;
        st_wdata     = next_key;

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                // busy_q still high here means this is the done cycle: start is ignored.
                if (start && !busy_q) begin
                    key_d        = key_in;
                    st_clr       = 1'b1;
                    st_we        = 1'b1;
                    st_widx      = '0;
                    st_wdata     = key_in;
                    busy_d       = 1'b1;
                    rk_valid_d   = 1'b1;
                    rk_idx_d     = '0;
                    rk_out_d     = key_in;
                    keys_ready_d = 1'b0;
                    round_d      = IDX_W'(1);
                    rcon_d       = RCON_INIT;
                    state_d      = ST_GEN;
                end
            end
            ST_GEN: begin
                busy_d     = 1'b1;
                key_d      = next_key;
                st_we      = 1'b1;
                st_widx    = round_q;
                rk_valid_d = 1'b1;
                rk_idx_d   = round_q;
                rk_out_d   = next_key;
                rcon_d     = xtime(rcon_q);
                round_d    = round_q + IDX_W'(1);
                if (round_q == IDX_W'(NR)) begin
                    done_d       = 1'b1;
                    keys_ready_d = 1'b1;
                    round_d      = '0;
                    rcon_d       = RCON_INIT;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            round_q      <= '0;
            rcon_q       <= RCON_INIT;
            key_q        <= '0;
            busy_q       <= 1'b0;
            rk_valid_q   <= 1'b0;
            rk_idx_q     <= '0;
            rk_out_q     <= '0;
            done_q       <= 1'b0;
            keys_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            round_q      <= round_d;
            rcon_q       <= rcon_d;
            key_q        <= key_d;
            busy_q       <= busy_d;
            rk_valid_q   <= rk_valid_d;
            rk_idx_q     <= rk_idx_d;
            rk_out_q     <= rk_out_d;
            done_q       <= done_d;
            keys_ready_q <= keys_ready_d;
        end
    end

    assign busy       = busy_q;
    assign rk_valid   = rk_valid_q;
    assign rk_idx     = rk_idx_q;
    assign rk_out     = rk_out_q;
    assign done       = done_q;
    assign keys_ready = keys_ready_q;

    aes_rk_store u_store (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (st_clr),
        .we_i    (st_we),
        .widx_i  (st_widx),
        .wdata_i (st_wdata),
        .ridx_i  (rd_idx),
        .rdata_o (rd_key)
    );

endmodule

// File: tb/tb_aes128_key_expand.sv
// Self-checking bench for aes128_key_expand with a GF(2^8)-derived S-box and
// a word-array key-schedule reference model.
module tb_aes128_key_expand;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic [31:0]  sw_x;
    logic [31:0]  sw_y;
    logic         busy;
    logic         rk_valid;
    logic [3:0]   rk_idx;
    logic [127:0] rk_out;
    logic         done;
    logic         keys_ready;
    logic [3:0]   rd_idx;
    logic [127:0] rd_key;

    int checks   = 0;
    int failures = 0;

    logic [7:0]   sbox [0:255];
    bit           sbox_ok = 1'b0;
    logic [127:0] rk_exp [0:10];
    logic [127:0] obs_rk [0:10];
    logic [31:0]  obs_swx0, obs_swy0;
    logic         obs_done10;
    logic [7:0]   rcon_tab [0:9];

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_RK1 = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    always #5 clk = ~clk;

    // External word substitution unit, combinational.
    assign sw_y = sbox_ok ? {sbox[sw_x[31:24]], sbox[sw_x[23:16]], sbox[sw_x[15:8]], sbox[sw_x[7:0]]} : 32'h0;

    aes128_key_expand dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .key_in     (key_in),
        .sw_x       (sw_x),
        .sw_y       (sw_y),
        .busy       (busy),
        .rk_valid   (rk_valid),
        .rk_idx     (rk_idx),
        .rk_out     (rk_out),
        .done       (done),
        .keys_ready (keys_ready),
        .rd_idx     (rd_idx),
        .rd_key     (rd_key)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [7:0] r = v;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    // Textbook key expansion over 44 words.
    task automatic model_expand(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] tmp;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 11; r++) rk_exp[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rand_key();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Full expansion with per-cycle checks; optional ignored starts at cycles 3 and 11.
    task automatic run_expand(input logic [127:0] key, input bit ign_mid, input bit ign_done);
        logic [127:0] prev;
        logic [31:0]  swy_cap;
        logic [7:0]   rc_obs;
        prev    = '0;
        swy_cap = '0;
        model_expand(key);
        key_in = key;
        start  = 1'b1;
        step();
        start  = 1'b0;
        key_in = rand_key();
        for (int r = 0; r <= 10; r++) begin
            obs_rk[r] = rk_out;
            if (r == 0) begin
                obs_swx0 = sw_x;
                obs_swy0 = sw_y;
            end
            if (r == 10) obs_done10 = done;
            chk($sformatf("rk_valid r%0d", r), 128'(rk_valid), 128'(1));
            chk($sformatf("rk_idx r%0d", r), 128'(rk_idx), 128'(r));
            chk($sformatf("rk_out r%0d", r), rk_out, rk_exp[r]);
            chk($sformatf("busy r%0d", r), 128'(busy), 128'(1));
            chk($sformatf("done r%0d", r), 128'(done), 128'(r == 10));
            chk($sformatf("keys_ready r%0d", r), 128'(keys_ready), 128'(r == 10));
            rd_idx = 4'(r);
            #1;
            chk($sformatf("rd_key fresh r%0d", r), rd_key, rk_exp[r]);
            if (r < 10) begin
                rd_idx = 4'(r + 1);
                #1;
                chk($sformatf("rd_key unwritten r%0d", r + 1), rd_key, 128'(0));
            end
            if (r > 0) begin
                rc_obs = rk_out[127:120] ^ prev[127:120] ^ swy_cap[31:24];
                chk($sformatf("rcon r%0d", r), 128'(rc_obs), 128'(rcon_tab[r-1]));
            end
            if (r < 10) begin
                chk($sformatf("sw_x r%0d", r), 128'(sw_x), 128'({rk_exp[r][23:0], rk_exp[r][31:24]}));
                swy_cap = sw_y;
                prev    = rk_out;
                start   = ign_mid && (r == 2);
                key_in  = rand_key();
                step();
                start   = 1'b0;
            end
        end
        start  = ign_done;
        key_in = rand_key();
        step();
        start  = 1'b0;
        chk("post busy", 128'(busy), 128'(0));
        chk("post rk_valid", 128'(rk_valid), 128'(0));
        chk("post done", 128'(done), 128'(0));
        chk("post keys_ready", 128'(keys_ready), 128'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_cnt;
        rcon_tab[0] = 8'h01; rcon_tab[1] = 8'h02; rcon_tab[2] = 8'h04; rcon_tab[3] = 8'h08;
        rcon_tab[4] = 8'h10; rcon_tab[5] = 8'h20; rcon_tab[6] = 8'h40; rcon_tab[7] = 8'h80;
        rcon_tab[8] = 8'h1b; rcon_tab[9] = 8'h36;
        build_sbox();
        sbox_ok = 1'b1;

        // Reset state
        rst = 1'b1; start = 1'b0; key_in = '0; rd_idx = '0;
        repeat (3) step();
        chk("rst busy", 128'(busy), 128'(0));
        chk("rst rk_valid", 128'(rk_valid), 128'(0));
        chk("rst rk_idx", 128'(rk_idx), 128'(0));
        chk("rst rk_out", rk_out, 128'(0));
        chk("rst done", 128'(done), 128'(0));
        chk("rst keys_ready", 128'(keys_ready), 128'(0));
        chk("rst rd_key", rd_key, 128'(0));
        rst = 1'b0;
        step();

        // FIPS-197 vector
        run_expand(FIPS_KEY, 1'b0, 1'b0);
        chk("fips rk0", obs_rk[0], FIPS_KEY);
        chk("fips sw_x", 128'(obs_swx0), 128'(32'hcf4f3c09));
        chk("fips sw_y", 128'(obs_swy0), 128'(32'h8a84eb01));
        chk("fips rk1", obs_rk[1], FIPS_RK1);
        chk("fips rk10", obs_rk[10], FIPS_RK10);
        chk("fips done10", 128'(obs_done10), 128'(1));

        // Read port after completion
        for (int i = 0; i < 16; i++) begin
            rd_idx = 4'(i);
            #1;
            chk($sformatf("rd idx%0d", i), rd_key, (i <= 10) ? rk_exp[i] : 128'(0));
        end
        rd_idx = 4'd1;  #1; chk("rd fips 1", rd_key, FIPS_RK1);
        rd_idx = 4'd10; #1; chk("rd fips 10", rd_key, FIPS_RK10);
        rd_idx = 4'd11; #1; chk("rd 11", rd_key, 128'(0));
        rd_idx = 4'd15; #1; chk("rd 15", rd_key, 128'(0));
        step();

        // All-zero key
        run_expand(128'(0), 1'b0, 1'b0);
        chk("zero rk1", obs_rk[1], ZERO_RK1);
        chk("zero rk10", obs_rk[10], ZERO_RK10);
        chk("zero keys_ready", 128'(keys_ready), 128'(1));

        // Starts while busy and on the done cycle are ignored; cycle 12 start accepted
        run_expand(FIPS_KEY, 1'b1, 1'b1);
        chk("ign rk1", obs_rk[1], FIPS_RK1);
        chk("ign rk10", obs_rk[10], FIPS_RK10);
        run_expand(rand_key(), 1'b0, 1'b0);

        // Reset in the middle of an expansion
        key_in = FIPS_KEY;
        start  = 1'b1;
        step();
        start  = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort busy", 128'(busy), 128'(0));
        chk("abort rk_valid", 128'(rk_valid), 128'(0));
        chk("abort keys_ready", 128'(keys_ready), 128'(0));
        chk("abort done", 128'(done), 128'(0));
        rd_idx = 4'd0; #1; chk("abort rd0", rd_key, 128'(0));
        rd_idx = 4'd3; #1; chk("abort rd3", rd_key, 128'(0));
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done || rk_valid) done_cnt++;
        end
        chk("abort no done", 128'(done_cnt), 128'(0));
        run_expand(rand_key(), 1'b0, 1'b0);

        // Random keys
        repeat (3) run_expand(rand_key(), 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
